lsu_mc: RTL and testbench

Parametrised multi-cycle load/store unit. It replaces the fixed single-cycle memory stage of the RV32I core with a stalling, handshaked data-memory port. The unit accepts one load or store per transaction from the core and generates byte-lane masks and lane-shifted store data. It holds the memory request until the memory returns `valid`, then sign- or zero-extends load data and returns a one-cycle response. It supports XLEN 32 or 64, rejects misaligned accesses, and drives a `busy` stall to the core.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_mc_if.sv | 43 ++++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_mc.sv | 198 +++++++++++++++++++
 tb/tb_lsu_mc.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit: funct3 codes,
// FSM state encoding and the funct3 legality helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_e;

    // Dword and unsigned-word forms only exist on a 64-bit datapath.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store,
                                      input logic wide);
        logic ok;
        ok = 1'b0;
        if (store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (wide && (f3 == F3_D));
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = wide;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mc_if.sv
// Core request/response and data-memory port of lsu_mc.
// master: the environment (core + memory); slave: the load/store unit.
interface lsu_mc_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic              busy;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic [4:0]        resp_rd;
    logic              mem_request;
    logic              mem_we_re;
    logic [NB-1:0]     mem_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_valid, mem_rdata,
        input  req_ready, busy, resp_valid, resp_err, resp_rdata, resp_rd,
        input  mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_valid, mem_rdata,
        output req_ready, busy, resp_valid, resp_err, resp_rdata, resp_rd,
        output mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, misalignment/illegal flags,
// lane-shifted store data and sign/zero-extended load data.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3,
    input  logic             store,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [NB-1:0]    mask,
    output logic             misalign,
    output logic             illegal,
    output logic [XLEN-1:0]  wdata_sh,
    output logic [XLEN-1:0]  rdata_ext
);

    logic [XLEN-1:0] rdata_sh;

    // Size-dependent mask and alignment check; funct3[1:0] encodes the size.
    always_comb begin
        mask     = '0;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: mask = NB'(1) << off;
            2'b01: begin
                mask     = NB'(3) << off;
                misalign = off[0];
            end
            2'b10: begin
                mask     = NB'(4'hF) << off;
                misalign = (off[1:0] != 2'b00);
            end
            default: begin
                mask     = '1;
                misalign = (off != '0);
            end
        endcase
    end

    assign illegal  = !f3_legal(funct3, store, (XLEN == 64));
    assign wdata_sh = wdata << {off, 3'b000};
    assign rdata_sh = rdata >> {off, 3'b000};

    // Truncate the addressed lanes to the access size, then extend to XLEN.
    always_comb begin
        rdata_ext = rdata_sh;
        case (funct3)
            F3_B:    rdata_ext = XLEN'($signed(rdata_sh[7:0]));
            F3_H:    rdata_ext = XLEN'($signed(rdata_sh[15:0]));
            F3_W:    rdata_ext = XLEN'($signed(rdata_sh[31:0]));
            F3_BU:   rdata_ext = XLEN'(rdata_sh[7:0]);
            F3_HU:   rdata_ext = XLEN'(rdata_sh[15:0]);
            F3_WU:   rdata_ext = XLEN'(rdata_sh[31:0]);
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: accepts one access from the core, holds a
// handshaked memory request until mem_valid, then returns a one-cycle response.
// Optional watchdog on the request state: define LSU_TIMEOUT_EN.
//
// state   | meaning
// ST_IDLE | ready for a new access
// ST_REQ  | memory request held until mem_valid (or watchdog expiry)
// ST_RESP | completion pulse, resp_err set only on watchdog expiry
// ST_ERR  | misaligned/illegal access reported, no memory access made
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic     clk,
    input  logic     rst,
    lsu_mc_if.slave  bus
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("lsu_mc: XLEN must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_mc: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              store_q, store_d;
    logic [NB-1:0]     mask_q, mask_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    logic              in_idle;
    logic [2:0]        al_funct3;
    logic              al_store;
    logic [OFF_W-1:0]  al_off;
    logic [NB-1:0]     al_mask;
    logic              al_misalign;
    logic              al_illegal;
    logic [XLEN-1:0]   al_wdata_sh;
    logic [XLEN-1:0]   al_rdata_ext;

    // One aligner serves both phases: request fields in IDLE, latched fields after.
    assign in_idle   = (state_q == ST_IDLE);
    assign al_funct3 = in_idle ? bus.req_funct3 : funct3_q;
    assign al_store  = in_idle ? bus.req_store : store_q;
    assign al_off    = in_idle ? bus.req_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (al_funct3),
        .store     (al_store),
        .off       (al_off),
        .wdata     (bus.req_wdata),
        .rdata     (bus.mem_rdata),
        .mask      (al_mask),
        .misalign  (al_misalign),
        .illegal   (al_illegal),
        .wdata_sh  (al_wdata_sh),
        .rdata_ext (al_rdata_ext)
    );

    // State and transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            store_q  <= 1'b0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            store_q  <= store_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Next-state logic and register updates.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        store_d  = store_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    rd_d     = bus.req_rd;
                    store_d  = bus.req_store;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (al_misalign || al_illegal) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_REQ;
                        mask_d  = al_mask;
                        wdata_d = bus.req_store ? al_wdata_sh : '0;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_valid) begin
                    state_d = ST_RESP;
                    rdata_d = store_q ? '0 : al_rdata_ext;
                    err_d   = 1'b0;
                end
`ifdef LSU_TIMEOUT_EN
                // Terminal count on a cycle without mem_valid drops the request.
                else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero outside their phase.
    always_comb begin
        bus.req_ready   = (state_q == ST_IDLE);
        bus.busy        = (state_q != ST_IDLE);
        bus.mem_request = (state_q == ST_REQ);
        bus.mem_we_re   = 1'b0;
        bus.mem_mask    = '0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_err    = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_rd     = '0;
        case (state_q)
            ST_REQ: begin
                bus.mem_we_re = store_q;
                bus.mem_mask  = mask_q;
                bus.mem_addr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
                bus.mem_wdata = wdata_q;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = rdata_q;
                bus.resp_rd    = rd_q;
            end
            ST_ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
                bus.resp_rd    = rd_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc (XLEN=32, TIMEOUT_CYCLES=8). Watchdog sequences
// are included when LSU_TIMEOUT_EN is defined.
module tb_lsu_mc;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_mc_if #(.XLEN(32), .ADDR_W(32)) bus ();

    lsu_mc #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          lat;
        logic        exp_err;
        logic [3:0]  exp_mask;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_req(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input int i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        chk({t, " ready"}, 32'(bus.req_ready), 32'd1);
        drive_req(v.store, v.f3, v.addr, v.wdata, v.rd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.exp_err) begin
            chk({t, " err_pulse"}, 32'({bus.resp_valid, bus.resp_err, bus.mem_request}), 32'b110);
            chk({t, " err_rdata"}, bus.resp_rdata, 32'd0);
            chk({t, " err_rd"}, 32'(bus.resp_rd), 32'(v.rd));
        end else begin
            chk({t, " req_busy"}, 32'({bus.mem_request, bus.busy, bus.resp_valid}), 32'b110);
            chk({t, " mem_addr"}, bus.mem_addr, v.exp_addr);
            chk({t, " mem_mask"}, 32'(bus.mem_mask), 32'(v.exp_mask));
            chk({t, " mem_we_re"}, 32'(bus.mem_we_re), 32'(v.store));
            if (v.store) chk({t, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
            for (int k = 0; k < v.lat; k++) begin
                @(negedge clk);
                chk($sformatf("%s hold%0d", t, k), 32'({bus.mem_request, bus.resp_valid}), 32'b10);
            end
            bus.mem_valid = 1'b1;
            bus.mem_rdata = v.rdata;
            @(negedge clk);
            bus.mem_valid = 1'b0;
            bus.mem_rdata = 32'hA5A5_5A5A;
            chk({t, " resp"}, 32'({bus.resp_valid, bus.resp_err, bus.mem_request}), 32'b100);
            chk({t, " rdata"}, bus.resp_rdata, v.exp_rdata);
            chk({t, " rd"}, 32'(bus.resp_rd), 32'(v.rd));
        end
        @(negedge clk);
        chk({t, " back_idle"}, 32'({bus.req_ready, bus.busy, bus.resp_valid}), 32'b100);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_rdata  = '0;

        //          st  f3     addr          wdata         rd     rdata         lat err mask   addr          wdata         rdata
        vt[0]  = '{1'b1, F3_W,  32'h100, 32'hDEADBEEF, 5'd1,  32'h0,        3, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, F3_B,  32'h103, 32'h0,        5'd5,  32'h80112233, 0, 1'b0, 4'h8, 32'h100, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{1'b0, F3_BU, 32'h103, 32'h0,        5'd7,  32'h80112233, 1, 1'b0, 4'h8, 32'h100, 32'h0,        32'h00000080};
        vt[3]  = '{1'b1, F3_H,  32'h102, 32'h0000ABCD, 5'd2,  32'h0,        0, 1'b0, 4'hC, 32'h100, 32'hABCD0000, 32'h0};
        vt[4]  = '{1'b0, F3_H,  32'h102, 32'h0,        5'd9,  32'h80010000, 2, 1'b0, 4'hC, 32'h100, 32'h0,        32'hFFFF8001};
        vt[5]  = '{1'b0, F3_HU, 32'h102, 32'h0,        5'd10, 32'h80010000, 0, 1'b0, 4'hC, 32'h100, 32'h0,        32'h00008001};
        vt[6]  = '{1'b0, F3_W,  32'h101, 32'h0,        5'd11, 32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
        vt[7]  = '{1'b0, F3_W,  32'h200, 32'h0,        5'd12, 32'h12345678, 0, 1'b0, 4'hF, 32'h200, 32'h0,        32'h12345678};
        vt[8]  = '{1'b1, F3_H,  32'h101, 32'h1234,     5'd13, 32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
        vt[9]  = '{1'b0, F3_D,  32'h108, 32'h0,        5'd14, 32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
        vt[10] = '{1'b0, F3_B,  32'h101, 32'h0,        5'd15, 32'h00007F00, 0, 1'b0, 4'h2, 32'h100, 32'h0,        32'h0000007F};
        vt[11] = '{1'b1, F3_B,  32'h302, 32'h000000A5, 5'd16, 32'h0,        1, 1'b0, 4'h4, 32'h300, 32'h00A50000, 32'h0};
        vt[12] = '{1'b0, 3'b111, 32'h100, 32'h0,       5'd17, 32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
        vt[13] = '{1'b0, F3_WU, 32'h100, 32'h0,        5'd18, 32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
        vt[14] = '{1'b1, F3_BU, 32'h100, 32'h11,       5'd19, 32'h0,        0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h0};

        // Reset state, while held and after release.
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'({bus.req_ready, bus.busy, bus.mem_request, bus.mem_we_re,
                             bus.resp_valid, bus.resp_err}), 32'b100000);
        chk("rst_bus", bus.mem_addr | bus.mem_wdata | bus.resp_rdata | 32'(bus.mem_mask) |
                       32'(bus.resp_rd), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release", 32'({bus.req_ready, bus.busy, bus.resp_valid}), 32'b100);

        // Table vectors, back to back.
        for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

        // mem_valid outside REQ is ignored.
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk("idle_mem_valid", 32'({bus.req_ready, bus.resp_valid, bus.mem_request}), 32'b100);
        end
        bus.mem_valid = 1'b0;

        // Reset asserted during REQ drops the request asynchronously.
        drive_req(1'b0, F3_W, 32'h400, 32'h0, 5'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstreq_in_req", 32'(bus.mem_request), 32'd1);
        #2 rst = 1'b0;
        #1 chk("rstreq_async", 32'({bus.mem_request, bus.busy, bus.req_ready}), 32'b001);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstreq_after", 32'({bus.req_ready, bus.busy, bus.resp_valid, bus.mem_request}), 32'b1000);
        end

`ifdef LSU_TIMEOUT_EN
        // Watchdog expiry: request held for exactly 8 cycles, then error response.
        drive_req(1'b0, F3_W, 32'h500, 32'h0, 5'd4);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 0;
        while (bus.mem_request === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(cyc), 32'd8);
        chk("to_resp", 32'({bus.resp_valid, bus.resp_err}), 32'b11);
        chk("to_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        chk("to_idle", 32'(bus.req_ready), 32'd1);

        // mem_valid on the limit cycle wins over the watchdog.
        drive_req(1'b0, F3_W, 32'h504, 32'h0, 5'd6);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("to2_hold%0d", k), 32'({bus.mem_request, bus.resp_valid}), 32'b10);
            @(negedge clk);
        end
        chk("to2_hold8", 32'({bus.mem_request, bus.resp_valid}), 32'b10);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("to2_resp", 32'({bus.resp_valid, bus.resp_err}), 32'b10);
        chk("to2_rdata", bus.resp_rdata, 32'hCAFE_F00D);
        @(negedge clk);
`else
        cyc = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
